// File: rtl/reg_mask_sequencer.sv
// Load/store-multiple sequencer: walks a register-select mask highest bit first,
// issuing one register/address transfer per handshake. Optional macro REGSEQ_XFER_COUNT_EN adds xfer_count.
module reg_mask_sequencer #(
  parameter int unsigned MASK_W = 31,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MASK_W-1:0] mask_in,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              is_store,
  output logic [MASK_W-1:0] mask_vec,
  input  logic [IDX_W-1:0]  enc_code,
  output logic              xfer_valid,
  input  logic              xfer_ready,
  output logic [IDX_W-1:0]  xfer_reg,
  output logic [ADDR_W-1:0] xfer_addr,
  output logic              xfer_store,
  output logic              busy,
`ifdef REGSEQ_XFER_COUNT_EN
  output logic [IDX_W:0]    xfer_count,
`endif
  output logic              done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [MASK_W-1:0] mask_clr_c;
  logic              start_acc_c;
  logic              xfer_fire_c;

  // Handshake and encoder pass-through are combinational so a transfer issues every cycle.
  assign xfer_valid  = (state == RUN) && (mask_vec != '0);
  assign xfer_reg    = (state == RUN) ? enc_code : '0;
  assign xfer_fire_c = xfer_valid && xfer_ready;
  assign start_acc_c = (state == IDLE) && start;
  assign mask_clr_c  = mask_vec & ~(MASK_W'(1) << enc_code);
  assign busy        = (state == RUN) || (state == DONE);
  assign done        = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (mask_in != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (xfer_fire_c && (mask_clr_c == '0)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An illegal enc_code (bit already clear) leaves the mask alone but still advances the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_vec   <= '0;
      xfer_addr  <= '0;
      xfer_store <= 1'b0;
    end else if (start_acc_c) begin
      mask_vec   <= mask_in;
      xfer_addr  <= base_addr;
      xfer_store <= is_store;
    end else if (xfer_fire_c) begin
      mask_vec   <= mask_clr_c;
      xfer_addr  <= xfer_addr + ADDR_W'(1);
    end
  end

`ifdef REGSEQ_XFER_COUNT_EN
  localparam int unsigned CNT_W = IDX_W + 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (start_acc_c) begin
      xfer_count <= '0;
    end else if (xfer_fire_c) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end
`endif

endmodule
